wb_egress_pack: RTL and testbench

WB_EGRESS_PACK -- requirements
Module: wb_egress_pack

---
 rtl/wb_egress_pack_pkg.sv | 40 ++++
 rtl/wb_egress_pack_burst_len_dec.sv | 24 ++
 rtl/wb_egress_pack.sv | 133 +++++++++++++
 tb/tb_wb_egress_pack.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_egress_pack_pkg.sv
// Shared encodings for the Wishbone egress packer: cycle/burst types,
// FIFO word layout and controller states.
package wb_egress_pack_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    localparam logic [1:0] WT_HDR  = 2'b10;
    localparam logic       WT_DATA = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR_W = 3'd1,
        WR    = 3'd2,
        RD    = 3'd3,
        ABRT  = 3'd4
    } state_t;

    function automatic logic [37:0] hdr_word(input logic we, input logic [1:0] bte,
                                             input logic [31:0] adr);
        return {WT_HDR, we, bte, 1'b0, adr};
    endfunction

    function automatic logic [37:0] data_word(input logic last, input logic [3:0] sel,
                                              input logic [31:0] dat);
        return {WT_DATA, last, sel, dat};
    endfunction

    function automatic logic is_end_cti(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/wb_egress_pack_burst_len_dec.sv
// Maximum beats carried under one header for the current cycle/burst type.
module burst_len_dec
    import wb_egress_pack_pkg::*;
#(
    parameter int MAX_LINEAR = 16
) (
    input  logic [2:0] cti,
    input  logic [1:0] bte,
    output logic [4:0] limit
);

    always_comb begin
        limit = 5'd1;
        if (cti == CTI_INCR || cti == CTI_CONST) begin
            case (bte)
                BTE_WRAP4:  limit = 5'd4;
                BTE_WRAP8:  limit = 5'd8;
                BTE_WRAP16: limit = 5'd16;
                default:    limit = 5'(MAX_LINEAR);
            endcase
        end
    end

endmodule

// File: rtl/wb_egress_pack.sv
// Packs Wishbone requests into header/data words for the egress FIFO,
// splitting long bursts and closing aborted writes with a terminator word.
//
// state | meaning
// IDLE  | no burst open; header written on stb&cyc when FIFO has room
// HDR_W | request seen while FIFO full; header pending
// WR    | write burst open, pushes become data words
// RD    | read burst open, waiting for final ack or cyc drop
// ABRT  | write cut short by cyc drop; emit terminator word
module wb_egress_pack
    import wb_egress_pack_pkg::*;
#(
    parameter int MAX_LINEAR = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [2:0]  cti_i,
    input  logic [1:0]  bte_i,
    input  logic        push_i,
    input  logic        ack_i,
    input  logic        fifo_full_i,
    output logic        stall_o,
    output logic        fifo_we_o,
    output logic [37:0] fifo_dat_o,
    output logic        err_o
);

    state_t     state, state_nx;
    logic [4:0] beat_cnt, beat_cnt_nx;
    logic [4:0] limit;
    logic       err_nx;
    logic       req;
    logic       last;

    burst_len_dec #(.MAX_LINEAR(MAX_LINEAR)) u_len_dec (
        .cti   (cti_i),
        .bte   (bte_i),
        .limit (limit)
    );

    assign req  = stb_i & cyc_i;
    assign last = is_end_cti(cti_i) || (5'(beat_cnt + 5'd1) >= limit);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state    <= IDLE;
            beat_cnt <= 5'd0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            err_o    <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        beat_cnt_nx = beat_cnt;
        err_nx      = err_o;
        fifo_we_o   = 1'b0;
        fifo_dat_o  = '0;
        stall_o     = fifo_full_i;

        case (state)
            IDLE, HDR_W: begin
                if (!req) begin
                    state_nx = IDLE;
                end else begin
                    // Stall the header cycle so no beat is accepted before the burst is open.
                    stall_o = 1'b1;
                    if (fifo_full_i) begin
                        state_nx = HDR_W;
                    end else begin
                        fifo_we_o   = 1'b1;
                        fifo_dat_o  = hdr_word(we_i, bte_i, adr_i);
                        beat_cnt_nx = 5'd0;
                        state_nx    = we_i ? WR : RD;
                    end
                end
            end

            WR: begin
                if (!cyc_i) begin
                    state_nx = ABRT;
                end else if (push_i) begin
                    if (fifo_full_i) begin
                        err_nx = 1'b1;
                    end else begin
                        fifo_we_o  = 1'b1;
                        fifo_dat_o = data_word(last, sel_i, dat_i);
                        if (last) begin
                            beat_cnt_nx = 5'd0;
                            state_nx    = IDLE;
                        end else begin
                            beat_cnt_nx = beat_cnt + 5'd1;
                        end
                    end
                end
            end

            RD: begin
                if (!cyc_i || (ack_i && stb_i && is_end_cti(cti_i))) begin
                    state_nx = IDLE;
                end
            end

            ABRT: begin
                stall_o = 1'b1;
                if (!fifo_full_i) begin
                    fifo_we_o   = 1'b1;
                    fifo_dat_o  = data_word(1'b1, 4'h0, 32'h0);
                    beat_cnt_nx = 5'd0;
                    state_nx    = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase

        if (wb_rst) begin
            fifo_we_o  = 1'b0;
            fifo_dat_o = '0;
            stall_o    = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_egress_pack.sv
// Directed scoreboard bench for wb_egress_pack: stimulus queues expected FIFO
// words, a negedge monitor pops and compares every write the DUT makes.
module tb_wb_egress_pack;
    import wb_egress_pack_pkg::*;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel_i = '0;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic [2:0]  cti_i = '0;
    logic [1:0]  bte_i = '0;
    logic        push_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        fifo_full_i = 1'b0;
    logic        stall_o;
    logic        fifo_we_o;
    logic [37:0] fifo_dat_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q[$];

    wb_egress_pack #(.MAX_LINEAR(16)) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .sel_i       (sel_i),
        .we_i        (we_i),
        .stb_i       (stb_i),
        .cyc_i       (cyc_i),
        .cti_i       (cti_i),
        .bte_i       (bte_i),
        .push_i      (push_i),
        .ack_i       (ack_i),
        .fifo_full_i (fifo_full_i),
        .stall_o     (stall_o),
        .fifo_we_o   (fifo_we_o),
        .fifo_dat_o  (fifo_dat_o),
        .err_o       (err_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge wb_clk) begin
        if (fifo_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h required=none", fifo_dat_o);
            end else begin
                check("fifo_word", 64'(fifo_dat_o), 64'(exp_q.pop_front()));
            end
        end else begin
            check("dat_zero_when_idle", 64'(fifo_dat_o), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic quiet();
        stb_i = 0; cyc_i = 0; push_i = 0; ack_i = 0; we_i = 0;
        cti_i = 3'b000; bte_i = 2'b00; sel_i = 0; dat_i = 0; fifo_full_i = 0;
    endtask

    function automatic logic [37:0] mk_hdr(input logic we, input logic [1:0] bte,
                                           input logic [31:0] adr);
        logic [37:0] w;
        w = 38'd0;
        w[37:36] = 2'b10;
        w[35]    = we;
        w[34:33] = bte;
        w[31:0]  = adr;
        return w;
    endfunction

    function automatic logic [37:0] mk_dat(input logic last, input logic [3:0] sel,
                                           input logic [31:0] dat);
        logic [37:0] w;
        w = 38'd0;
        w[36]    = last;
        w[35:32] = sel;
        w[31:0]  = dat;
        return w;
    endfunction

    task automatic hdr(input logic we, input logic [31:0] adr, input logic [2:0] cti,
                       input logic [1:0] bte, input logic [37:0] exp);
        stb_i = 1; cyc_i = 1; we_i = we; adr_i = adr; cti_i = cti; bte_i = bte;
        push_i = 0; ack_i = 0; fifo_full_i = 0;
        exp_q.push_back(exp);
        #1;
        check("hdr_stall", 64'(stall_o), 64'd1);
        step();
    endtask

    task automatic wr_beat(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic [2:0] cti, input logic [1:0] bte, input logic last);
        stb_i = 1; cyc_i = 1; we_i = 1; adr_i = adr; dat_i = dat; sel_i = sel;
        cti_i = cti; bte_i = bte; push_i = 1; ack_i = 1; fifo_full_i = 0;
        exp_q.push_back(mk_dat(last, sel, dat));
        #1;
        check("beat_stall", 64'(stall_o), 64'd0);
        step();
    endtask

    initial begin
        quiet();
        wb_rst = 1;
        #2;
        check("rst_stall", 64'(stall_o), 64'd1);
        check("rst_we", 64'(fifo_we_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_state", 64'(dut.state), 64'(IDLE));
        stb_i = 1; cyc_i = 1; we_i = 1;
        #1;
        check("rst_no_hdr", 64'(fifo_we_o), 64'd0);
        quiet();
        step(); step();
        wb_rst = 0;
        step();

        // Classic write
        hdr(1, 32'h100, 3'b000, 2'b00, 38'h28_0000_0100);
        wr_beat(32'h100, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 1'b1);
        quiet();
        #1;
        check("classic_stall_after", 64'(stall_o), 64'd0);
        check("classic_state", 64'(dut.state), 64'(IDLE));
        step();

        // Wrap4 write
        hdr(1, 32'h200, 3'b010, 2'b01, 38'h2A_0000_0200);
        for (int i = 0; i < 4; i++)
            wr_beat(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 3'b010, 2'b01, i == 3);
        quiet();
        #1;
        check("wrap4_state", 64'(dut.state), 64'(IDLE));
        step();

        // Linear 20 beats, split at 16
        hdr(1, 32'h1000, 3'b010, 2'b00, 38'h28_0000_1000);
        for (int i = 0; i < 16; i++)
            wr_beat(32'h1000 + 32'(4 * i), 32'h5000 + 32'(i), 4'h3, 3'b010, 2'b00, i == 15);
        hdr(1, 32'h1040, 3'b010, 2'b00, mk_hdr(1'b1, 2'b00, 32'h1040));
        for (int i = 16; i < 20; i++)
            wr_beat(32'h1000 + 32'(4 * i), 32'h5000 + 32'(i), 4'hC,
                    (i == 19) ? 3'b111 : 3'b010, 2'b00, i == 19);
        quiet();
        #1;
        check("linear_state", 64'(dut.state), 64'(IDLE));
        step();

        // Wrap8 write aborted after 2 beats, FIFO full for 3 cycles
        hdr(1, 32'h300, 3'b010, 2'b10, mk_hdr(1'b1, 2'b10, 32'h300));
        wr_beat(32'h300, 32'h1111_1111, 4'hF, 3'b010, 2'b10, 1'b0);
        wr_beat(32'h304, 32'h2222_2222, 4'hF, 3'b010, 2'b10, 1'b0);
        quiet();
        fifo_full_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_full_stall", 64'(stall_o), 64'd1);
            check("abort_full_nowrite", 64'(fifo_we_o), 64'd0);
            step();
        end
        fifo_full_i = 0;
        exp_q.push_back(38'h10_0000_0000);
        #1;
        check("abort_word_stall", 64'(stall_o), 64'd1);
        step();
        #1;
        check("abort_state", 64'(dut.state), 64'(IDLE));
        check("abort_err", 64'(err_o), 64'd0);
        step();

        // Read, wrap8, exit on eob ack; second read gets its own header
        hdr(0, 32'h400, 3'b010, 2'b10, 38'h24_0000_0400);
        stb_i = 1; cyc_i = 1; we_i = 0; cti_i = 3'b010; push_i = 1; ack_i = 1;
        step(); step();
        cti_i = 3'b111;
        step();
        push_i = 0; ack_i = 0;
        #1;
        check("rd_state", 64'(dut.state), 64'(IDLE));
        hdr(0, 32'h500, 3'b000, 2'b00, 38'h20_0000_0500);
        stb_i = 1; cyc_i = 1; we_i = 0; cti_i = 3'b000; ack_i = 1;
        step();
        quiet();
        #1;
        check("rd2_state", 64'(dut.state), 64'(IDLE));
        step();

        // Push into full FIFO, sticky err, reset mid-burst
        hdr(1, 32'h600, 3'b010, 2'b00, mk_hdr(1'b1, 2'b00, 32'h600));
        wr_beat(32'h600, 32'h6666_6666, 4'hF, 3'b010, 2'b00, 1'b0);
        push_i = 1; fifo_full_i = 1; dat_i = 32'h7777_7777;
        #1;
        check("drop_stall", 64'(stall_o), 64'd1);
        check("drop_nowrite", 64'(fifo_we_o), 64'd0);
        step();
        push_i = 0; fifo_full_i = 0;
        #1;
        check("drop_err", 64'(err_o), 64'd1);
        check("drop_cnt", 64'(dut.beat_cnt), 64'd1);
        step(); step();
        check("err_sticky", 64'(err_o), 64'd1);
        wb_rst = 1;
        #1;
        check("rst_mid_stall", 64'(stall_o), 64'd1);
        check("rst_mid_we", 64'(fifo_we_o), 64'd0);
        check("rst_mid_err", 64'(err_o), 64'd0);
        check("rst_mid_state", 64'(dut.state), 64'(IDLE));
        quiet();
        step();
        wb_rst = 0;
        step();
        hdr(1, 32'h700, 3'b000, 2'b00, mk_hdr(1'b1, 2'b00, 32'h700));
        wr_beat(32'h700, 32'h0BAD_F00D, 4'h5, 3'b000, 2'b00, 1'b1);
        quiet();
        step(); step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
